// File: rtl/alu_seq_muldiv_if.sv
// Handshake/operand bundle for the sequential execute-stage ALU.
// The producer side uses master and the ALU uses slave.
interface alu_seq_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       aluop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, a, b, aluop, out_ready,
      input  in_ready, out_valid, result, zero, overflow, illegal
   );

   modport slave (
      input  in_valid, a, b, aluop, out_ready,
      output in_ready, out_valid, result, zero, overflow, illegal
   );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU: RV32I ops in one cycle, mul/div iterated one bit per cycle.
// Divider is built only when ALU_SEQ_DIV_EN is defined; otherwise divide opcodes report illegal.
module alu_seq_muldiv #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset_n,
   alu_seq_muldiv_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 overflow_q, overflow_d;
   logic                 illegal_q, illegal_d;
   logic [SHW:0]         cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opr_q, opr_d;
   logic                 sel_q, sel_d;
   logic                 load;

   logic                 sub;
   logic [WIDTH-1:0]     b_eff, sum, alu_res;
   logic                 alu_ovf;
   logic [SHW-1:0]       shamt;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_acc;

`ifdef ALU_SEQ_DIV_EN
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   logic                 neg_q, neg_d;
   logic                 div_signed;
   logic [WIDTH-1:0]     abs_a, abs_b, div_val;
   logic [WIDTH:0]       div_trial;
   logic [2*WIDTH-1:0]   div_acc;
`endif

   // Single-cycle integer ops; add and sub share one adder with b inverted for sub.
   always_comb begin
      sub     = (bus.aluop == 4'b0001);
      b_eff   = sub ? ~bus.b : bus.b;
      sum     = bus.a + b_eff + {{(WIDTH-1){1'b0}}, sub};
      shamt   = bus.b[SHW-1:0];
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.aluop)
         4'b0000, 4'b0001: begin
            alu_res = sum;
            alu_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         4'b0010: alu_res = bus.a & bus.b;
         4'b0011: alu_res = bus.a | bus.b;
         4'b0100: alu_res = bus.a ^ bus.b;
         4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
         4'b0110: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
         4'b0111: alu_res = bus.a << shamt;
         4'b1000: alu_res = bus.a >> shamt;
         4'b1001: alu_res = $signed(bus.a) >>> shamt;
         default: alu_res = '0;
      endcase
   end

   // Shift-add step: acc = {partial high, remaining multiplier bits}.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opr_q};
      mul_acc = {mul_sum, acc_q[WIDTH-1:1]};
   end

`ifdef ALU_SEQ_DIV_EN
   // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
   always_comb begin
      div_signed = bus.aluop[1];
      abs_a      = (div_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      abs_b      = (div_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      div_trial  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opr_q};
      div_acc    = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      div_val    = sel_q ? div_acc[2*WIDTH-1:WIDTH] : div_acc[WIDTH-1:0];
   end
`endif

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
      illegal_d  = illegal_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opr_d      = opr_q;
      sel_d      = sel_q;
      load       = 1'b0;
`ifdef ALU_SEQ_DIV_EN
      neg_d      = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               cnt_d = '0;
               sel_d = bus.aluop[0];
               if (bus.aluop[3:1] == 3'b101) begin
                  opr_d   = bus.a;
                  acc_d   = {{WIDTH{1'b0}}, bus.b};
                  state_d = MUL;
               end else if (bus.aluop[3:2] == 2'b11) begin
`ifdef ALU_SEQ_DIV_EN
                  if (bus.b == '0) begin
                     load       = 1'b1;
                     result_d   = bus.aluop[0] ? bus.a : '1;
                     overflow_d = 1'b0;
                     illegal_d  = 1'b0;
                     state_d    = DONE;
                  end else if (div_signed && bus.a == MIN_VAL && bus.b == '1) begin
                     load       = 1'b1;
                     result_d   = bus.aluop[0] ? '0 : MIN_VAL;
                     overflow_d = 1'b0;
                     illegal_d  = 1'b0;
                     state_d    = DONE;
                  end else begin
                     opr_d   = abs_b;
                     acc_d   = {{WIDTH{1'b0}}, abs_a};
                     neg_d   = div_signed && (bus.aluop[0] ? bus.a[WIDTH-1]
                                                           : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]));
                     state_d = DIV;
                  end
`else
                  load       = 1'b1;
                  result_d   = '0;
                  overflow_d = 1'b0;
                  illegal_d  = 1'b1;
                  state_d    = DONE;
`endif
               end else begin
                  load       = 1'b1;
                  result_d   = alu_res;
                  overflow_d = alu_ovf;
                  illegal_d  = 1'b0;
                  state_d    = DONE;
               end
            end
         end
         MUL: begin
            acc_d = mul_acc;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               load       = 1'b1;
               result_d   = sel_q ? mul_acc[2*WIDTH-1:WIDTH] : mul_acc[WIDTH-1:0];
               overflow_d = 1'b0;
               illegal_d  = 1'b0;
               state_d    = DONE;
            end
         end
         DIV: begin
`ifdef ALU_SEQ_DIV_EN
            acc_d = div_acc;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               load       = 1'b1;
               result_d   = neg_q ? -div_val : div_val;
               overflow_d = 1'b0;
               illegal_d  = 1'b0;
               state_d    = DONE;
            end
`else
            state_d = IDLE;
`endif
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load) zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         opr_q      <= '0;
         sel_q      <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         neg_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         overflow_q <= overflow_d;
         illegal_q  <= illegal_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opr_q      <= opr_d;
         sel_q      <= sel_d;
`ifdef ALU_SEQ_DIV_EN
         neg_q      <= neg_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = overflow_q;
   assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Bench for alu_seq_muldiv: directed vector table, multi-cycle corner sequences,
// and random ops against an arithmetic reference model (honours ALU_SEQ_DIV_EN).
module tb_alu_seq_muldiv;
   logic clk;
   logic reset_n;
   int   n_cmp;
   int   n_fail;

   alu_seq_muldiv_if #(.WIDTH(32)) bus ();

   alu_seq_muldiv #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs [23];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic is_div(input logic [3:0] op);
      return op[3:2] == 2'b11;
   endfunction

   // Reference model: plain 64-bit arithmetic from the opcode definitions.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ovf, output logic ill,
                                 output int lat);
      longint          sa, sb, s;
      longint unsigned p;
      logic [31:0]     t;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      p   = {32'b0, a} * {32'b0, b};
      r   = '0;
      ovf = 1'b0;
      ill = 1'b0;
      lat = 1;
      case (op)
         4'd0, 4'd1: begin
            s   = (op == 4'd0) ? sa + sb : sa - sb;
            t   = 32'(s);
            r   = t;
            ovf = (s != longint'($signed(t)));
         end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd6:  r = (a < b) ? 32'd1 : 32'd0;
         4'd7:  r = a << b[4:0];
         4'd8:  r = a >> b[4:0];
         4'd9:  r = 32'(sa >>> b[4:0]);
         4'd10: begin r = p[31:0];  lat = 33; end
         4'd11: begin r = p[63:32]; lat = 33; end
         default: begin
`ifdef ALU_SEQ_DIV_EN
            case (op)
               4'd12:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
               4'd13:   r = (b == 0) ? a : a % b;
               4'd14:   r = (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
               default: r = (b == 0) ? a : 32'(sa % sb);
            endcase
            lat = (b == 0 || (op[1] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33;
`else
            ill = 1'b1;
`endif
         end
      endcase
   endfunction

   // Issue one op, measure edges from accept to out_valid, check, hold, then retire.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eovf, input logic eill,
                        input int elat, input int hold, input string name);
      int lat;
      int waitc;
      waitc = 0;
      @(negedge clk);
      while (!bus.in_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      check({name, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.aluop    = op;
      bus.a        = a;
      bus.b        = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.aluop    = 4'($urandom);
      bus.a        = $urandom;
      bus.b        = $urandom;
      lat = 1;
      while (!bus.out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check({name, ".latency"},  32'(lat),                 32'(elat));
      check({name, ".result"},   bus.result,               er);
      check({name, ".zero"},     {31'b0, bus.zero},        {31'b0, er == 32'd0});
      check({name, ".overflow"}, {31'b0, bus.overflow},    {31'b0, eovf});
      check({name, ".illegal"},  {31'b0, bus.illegal},     {31'b0, eill});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, ".hold_result"},    bus.result,            er);
         check({name, ".hold_out_valid"}, {31'b0, bus.out_valid}, 32'd1);
         check({name, ".hold_in_ready"},  {31'b0, bus.in_ready},  32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, ".retire_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
      check({name, ".retire_in_ready"},  {31'b0, bus.in_ready},  32'd1);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] er, ra, rb;
      logic        eovf, eill, seen;
      logic [3:0]  op;
      int          elat;

      n_cmp  = 0;
      n_fail = 0;
      vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1};
      vecs[1]  = '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};
      vecs[2]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1};
      vecs[3]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1};
      vecs[4]  = '{4'd3,  32'hA5A50000, 32'h0000A5A5, 32'hA5A5A5A5, 1'b0, 1};
      vecs[5]  = '{4'd4,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1};
      vecs[6]  = '{4'd5,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
      vecs[7]  = '{4'd6,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1};
      vecs[8]  = '{4'd7,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1};
      vecs[9]  = '{4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1};
      vecs[10] = '{4'd9,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1};
      vecs[11] = '{4'd10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 33};
      vecs[12] = '{4'd11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 33};
      vecs[13] = '{4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 33};
      vecs[14] = '{4'd15, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 33};
      vecs[15] = '{4'd12, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1};
      vecs[16] = '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
      vecs[17] = '{4'd15, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
      vecs[18] = '{4'd12, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 33};
      vecs[19] = '{4'd13, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1};
      vecs[20] = '{4'd13, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0, 33};
      vecs[21] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
      vecs[22] = '{4'd15, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};

      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.aluop     = 4'd0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(negedge clk);
      check("rst.in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst.result",    bus.result,             32'd0);
      check("rst.flags",     {29'b0, bus.zero, bus.overflow, bus.illegal}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rel.in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("rel.out_valid", {31'b0, bus.out_valid}, 32'd0);

      for (int i = 0; i < 23; i++) begin
         er   = vecs[i].res;
         eill = 1'b0;
         elat = vecs[i].lat;
`ifndef ALU_SEQ_DIV_EN
         if (is_div(vecs[i].op)) begin
            er   = 32'd0;
            eill = 1'b1;
            elat = 1;
         end
`endif
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, er, vecs[i].ovf, eill, elat, 0,
               $sformatf("vec%0d", i));
      end

      do_op(4'd10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 5, "backpressure");

      // Reset in the middle of a multiply must abort it without a valid result.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.aluop    = 4'd10;
      bus.a        = 32'h12345678;
      bus.b        = 32'h9ABCDEF0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort.in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("abort.out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("abort.result",    bus.result,             32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      check("abort.no_valid", {31'b0, seen}, 32'd0);
      do_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 0, "after_abort");

      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         ra = pick();
         rb = pick();
         model(op, ra, rb, er, eovf, eill, elat);
         do_op(op, ra, rb, er, eovf, eill, elat, 0, $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
